bram_arbiter: RTL

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port BRAM with round-robin
// conflict resolution, fixed one-cycle response latency and a saturating conflict counter.
module bram_arbiter #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              bram_enable,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {
    WIN_FETCH = 1'b0,
    WIN_DATA  = 1'b1
  } winner_t;

  winner_t     last_winner_q, last_winner_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic        d_err_q, d_err_d;
  logic        d_rd_q, d_rd_d;
  logic [15:0] cnt_q, cnt_d;

  logic d_legal;
  logic conflict;
  logic unused_if_bits;

  // Fetch addresses wrap, so the byte offset and the bits above the BRAM are dropped.
  assign unused_if_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0]};

  assign d_legal  = (d_addr[1:0] == 2'b00) && ((d_addr >> (ADDR_W + 2)) == 32'd0);
  assign conflict = if_req && d_req;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (conflict) begin
        if (last_winner_q == WIN_DATA) if_gnt = 1'b1;
        else                           d_gnt  = 1'b1;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  always_comb begin
    bram_enable = if_gnt || (d_gnt && d_legal);
    bram_we     = (d_gnt && d_legal && d_we) ? d_be : 4'b0000;
    bram_addr   = d_gnt ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
    bram_wdata  = d_wdata;
  end

  always_comb begin
    if_rvalid_d   = if_gnt;
    d_rvalid_d    = d_gnt;
    d_err_d       = d_gnt && !d_legal;
    d_rd_d        = d_gnt && d_legal && !d_we;
    last_winner_d = last_winner_q;
    if (conflict) last_winner_d = if_gnt ? WIN_FETCH : WIN_DATA;
    cnt_d = cnt_q;
    if (conflict && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= WIN_DATA;
      if_rvalid_q   <= 1'b0;
      d_rvalid_q    <= 1'b0;
      d_err_q       <= 1'b0;
      d_rd_q        <= 1'b0;
      cnt_q         <= 16'd0;
    end else begin
      last_winner_q <= last_winner_d;
      if_rvalid_q   <= if_rvalid_d;
      d_rvalid_q    <= d_rvalid_d;
      d_err_q       <= d_err_d;
      d_rd_q        <= d_rd_d;
      cnt_q         <= cnt_d;
    end
  end

  // A response still in flight when reset rises is masked immediately, not a cycle later.
  always_comb begin
    if_rvalid    = if_rvalid_q && !reset;
    d_rvalid     = d_rvalid_q && !reset;
    d_err        = d_rvalid && d_err_q;
    if_rdata     = if_rvalid ? bram_rdata : 32'd0;
    d_rdata      = (d_rvalid && d_rd_q) ? bram_rdata : 32'd0;
    conflict_cnt = cnt_q;
  end

endmodule
